// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 serial transmitter with a one-entry holding register.
// Ports: clk, rst (async, active high), data/valid/ready byte handshake,
//        tx serial line (idle high), busy while framing, done end-of-frame pulse.
// Optional: define UART_TX_PARITY_EN to insert an even-parity bit after DATA.
module uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic          stop_idx;
    logic          stop_next;
    logic          tx_next;
    logic          done_next;
    logic          load;
    logic          hold_full;
    logic [7:0]    hold_data;
    logic [7:0]    frame;
    logic          bit_end;
    logic          stop_last;

    assign ready     = ~hold_full;
    assign busy      = (state != IDLE);
    assign bit_end   = (cnt == CW'(CLKS_PER_BIT - 1));
    assign stop_last = (stop_idx == 1'(STOP_BITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            tx       <= 1'b1;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            idx      <= idx_next;
            stop_idx <= stop_next;
            tx       <= tx_next;
            done     <= done_next;
        end
    end

    // Holding register: accept only when empty; emptied when the FSM
    // copies it into the frame register. The two never coincide since
    // load requires a full register and accept an empty one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            frame     <= '0;
        end else begin
            if (valid && ready) begin
                hold_full <= 1'b1;
                hold_data <= data;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            if (load) begin
                frame <= hold_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        idx_next   = idx;
        stop_next  = stop_idx;
        load       = 1'b0;
        done_next  = 1'b0;
        tx_next    = 1'b1;

        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (hold_full) begin
                    state_next = START;
                    load       = 1'b1;
                end
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == 3'd7) state_next = AFTER_DATA;
                    else             idx_next   = idx + 3'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (stop_last) begin
                        done_next = 1'b1;
                        // A queued byte chains straight into the next
                        // start bit with no idle cycle.
                        if (hold_full) begin
                            state_next = START;
                            load       = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        stop_next = stop_idx + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Bit timer restarts on every bit boundary and every state entry.
        if (bit_end || state_next != state) cnt_next = '0;
        if (state_next != state) begin
            idx_next  = '0;
            stop_next = 1'b0;
        end

        // tx is registered, so it is driven from the upcoming state.
        unique case (state_next)
            IDLE:    tx_next = 1'b1;
            START:   tx_next = 1'b0;
            DATA:    tx_next = frame[idx_next];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = ^frame;
`endif
            STOP:    tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks two uart_tx instances (1 and 2 stop bits) against a
// frame-time model, plus literal frame patterns and done timing.
module tb_uart_tx;

    localparam int CPB = 104;
`ifdef UART_TX_PARITY_EN
    localparam int          PB  = 1;
    localparam int          NB  = 11;
    localparam logic [11:0] P55 = 12'h4AA;
    localparam logic [11:0] P81 = 12'h502;
    localparam logic [11:0] PFF = 12'hDFE;
`else
    localparam int          PB  = 0;
    localparam int          NB  = 10;
    localparam logic [11:0] P55 = 12'h2AA;
    localparam logic [11:0] P81 = 12'h302;
    localparam logic [11:0] PFF = 12'h7FE;
`endif
    localparam int FL = NB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_s [2];
    logic [1:0] valid_s;
    logic [1:0] tx_o;
    logic [1:0] ready_o;
    logic [1:0] busy_o;
    logic [1:0] done_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dq0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        uart_tx #(
            .CLKS_PER_BIT(CPB),
            .STOP_BITS(g + 1)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .data(data_s[g]),
            .valid(valid_s[g]),
            .ready(ready_o[g]),
            .tx(tx_o[g]),
            .busy(busy_o[g]),
            .done(done_o[g])
        );
    end

    // Model: a frame is a time index t over (10+parity+extra stop)*CPB cycles.
    int         m_t    [2] = '{0, 0};
    bit         m_act  [2] = '{0, 0};
    bit         m_full [2] = '{0, 0};
    bit         m_done [2] = '{0, 0};
    bit         m_acc  [2] = '{0, 0};
    logic [7:0] m_hold [2];
    logic [7:0] m_frame[2] = '{8'h00, 8'h00};

    function automatic int flen(input int g);
        return (10 + PB + g) * CPB;
    endfunction

    function automatic logic fbit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (PB == 1 && k == 9) return ^d;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < 2; g++) begin
                m_t[g] = 0;
                m_act[g] = 0;
                m_full[g] = 0;
                m_done[g] = 0;
                m_acc[g] = 0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                m_acc[g] = valid_s[g] && !m_full[g];
                m_done[g] = 0;
                if (m_act[g]) begin
                    m_t[g]++;
                    if (m_t[g] == flen(g)) begin
                        m_done[g] = 1;
                        m_act[g] = 0;
                    end
                end
                if (!m_act[g] && m_full[g]) begin
                    m_act[g] = 1;
                    m_t[g] = 0;
                    m_frame[g] = m_hold[g];
                    m_full[g] = 0;
                end
                if (m_acc[g]) begin
                    m_full[g] = 1;
                    m_hold[g] = data_s[g];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            string s;
            logic  et;
            s  = (g == 0) ? "0" : "1";
            et = m_act[g] ? fbit(m_frame[g], m_t[g] / CPB) : 1'b1;
            chk({"m_tx", s}, tx_o[g], et);
            chk({"m_ready", s}, ready_o[g], !m_full[g]);
            chk({"m_busy", s}, busy_o[g], m_act[g]);
            chk({"m_done", s}, done_o[g], m_done[g]);
        end
        if (done_o[0]) dq0.push_back(cyc);
    end

    task automatic send(input int g, input logic [7:0] d);
        int n;
        n = 0;
        valid_s[g] = 1'b1;
        data_s[g]  = d;
        do begin
            @(negedge clk);
            n++;
        end while (!m_acc[g] && n < 5000);
        chk("send_accept", m_acc[g], 1);
        valid_s[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        while ((m_act[g] || m_full[g]) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", n < 20000, 1);
        repeat (2) @(negedge clk);
    endtask

    // Called on the negedge right after the accepting edge.
    task automatic check_frame(input int g, input logic [11:0] pat,
                               input int nbits, input string name);
        int fl;
        fl = nbits * CPB;
        chk({name, "_pre"}, tx_o[g], 1);
        for (int j = 0; j <= fl; j++) begin
            @(negedge clk);
            if (j == 0) chk({name, "_fall"}, tx_o[g], 0);
            if (j % CPB == CPB / 2)
                chk({name, "_bit"}, tx_o[g], pat[j / CPB]);
            if (j == fl - 1) chk({name, "_nodone"}, done_o[g], 0);
            if (j == fl) chk({name, "_done"}, done_o[g], 1);
        end
    endtask

    initial begin
        int n;
        int base;
        valid_s   = 2'b00;
        data_s[0] = 8'h00;
        data_s[1] = 8'h00;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_o[0], 1);
        chk("rst_ready", ready_o[0], 1);
        chk("rst_busy", busy_o[0], 0);
        chk("rst_done", done_o[0], 0);
        rst = 1'b0;
        @(negedge clk);

        send(0, 8'h55);
        check_frame(0, P55, NB, "f55");
        wait_idle(0);
`ifdef UART_TX_PARITY_EN
        send(0, 8'h07);
        check_frame(0, 12'h60E, 11, "f07");
        wait_idle(0);
`endif

        // Back-to-back, then a changing offer held while ready is low.
        base = dq0.size();
        send(0, 8'hA3);
        send(0, 8'h3C);
        valid_s[0] = 1'b1;
        n = 0;
        do begin
            data_s[0] = 8'(cyc * 37 + 11);
            @(negedge clk);
            n++;
        end while (!m_acc[0] && n < 5000);
        chk("hold_accept", m_acc[0], 1);
        valid_s[0] = 1'b0;
        wait_idle(0);
        chk("b2b_count", dq0.size() - base, 3);
        if (dq0.size() - base == 3) begin
            chk("b2b_gap1", dq0[base+1] - dq0[base], FL);
            chk("b2b_gap2", dq0[base+2] - dq0[base+1], FL);
        end

        // Offer arriving on the very edge the stop bit ends.
        send(0, 8'h12);
        n = 0;
        while (!(m_act[0] && m_t[0] == FL - 1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("end_wait", n < 5000, 1);
        valid_s[0] = 1'b1;
        data_s[0]  = 8'h34;
        @(negedge clk);
        valid_s[0] = 1'b0;
        chk("edge_done", done_o[0], 1);
        chk("edge_busy", busy_o[0], 0);
        chk("edge_ready", ready_o[0], 0);
        chk("edge_tx", tx_o[0], 1);
        @(negedge clk);
        chk("edge_start_tx", tx_o[0], 0);
        chk("edge_start_busy", busy_o[0], 1);
        wait_idle(0);

        // Reset during data bit 3 with a second byte pending.
        send(0, 8'hC6);
        send(0, 8'h99);
        n = 0;
        while (!(m_act[0] && m_t[0] == 4 * CPB + 50) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("bit3_wait", n < 5000, 1);
        base = dq0.size();
        #2 rst = 1'b1;
        #1;
        chk("abort_tx", tx_o[0], 1);
        chk("abort_busy", busy_o[0], 0);
        chk("abort_ready", ready_o[0], 1);
        chk("abort_done", done_o[0], 0);
        repeat (3) @(negedge clk);
        data_s[0]  = 8'h81;
        valid_s[0] = 1'b1;
        rst        = 1'b0;
        @(negedge clk);
        chk("post_rst_accept", ready_o[0], 0);
        valid_s[0] = 1'b0;
        check_frame(0, P81, NB, "f81");
        wait_idle(0);
        chk("abort_no_done", dq0.size() - base, 1);

        // Two stop bits.
        send(1, 8'hFF);
        check_frame(1, PFF, NB + 1, "fff");
        wait_idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
